// File: rtl/gf180mcu_fd_sc_mcu7t5v0__latwr_seq_if.sv
// Command channel of the latch write sequencer: a valid/ready request
// carrying write/preset commands, and a one-cycle DONE/ERR completion.
interface gf180mcu_fd_sc_mcu7t5v0__latwr_seq_if #(
    parameter int ENTRIES = 8,
    parameter int WIDTH   = 8
);
    localparam int AW = $clog2(ENTRIES);

    logic             VALID;
    logic             OP;
    logic [AW-1:0]    ADDR;
    logic [WIDTH-1:0] WDATA;
    logic             READY;
    logic             DONE;
    logic             ERR;

    modport master (
        output VALID, OP, ADDR, WDATA,
        input  READY, DONE, ERR
    );

    modport slave (
        input  VALID, OP, ADDR, WDATA,
        output READY, DONE, ERR
    );
endinterface

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__latwr_seq.sv
// Write/preset sequencer for a bank of latsnq-style latches. Every latch
// control output comes straight from a flop so E and SETN are glitch-free.
module gf180mcu_fd_sc_mcu7t5v0__latwr_seq #(
    parameter int ENTRIES   = 8,
    parameter int WIDTH     = 8,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic                 CLK,
    input  logic                 RN,
    inout  wire                  VDD,
    inout  wire                  VSS,
    gf180mcu_fd_sc_mcu7t5v0__latwr_seq_if.slave bus,
    output logic [ENTRIES-1:0]   E,
    output logic [WIDTH-1:0]     D,
    output logic                 SETN
);
    localparam int AW   = $clog2(ENTRIES);
    localparam int MAX1 = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAXC = (MAX1 > HOLD_CYC) ? MAX1 : HOLD_CYC;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [2:0] S_INIT  = 3'd0;
    localparam logic [2:0] S_REC   = 3'd1;
    localparam logic [2:0] S_IDLE  = 3'd2;
    localparam logic [2:0] S_SETUP = 3'd3;
    localparam logic [2:0] S_PULSE = 3'd4;
    localparam logic [2:0] S_HOLD  = 3'd5;
    localparam logic [2:0] S_PRE   = 3'd6;

    logic [2:0]          state, state_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic [AW-1:0]       addr_q;
    logic                bad_q;
    logic                pre_q;
    logic                accept;
    logic                done_nxt;
    logic [ENTRIES-1:0]  e_nxt;

    wire unused_supply;
    assign unused_supply = VDD ^ VSS;

    // Dwell time of each timed state, loaded as (cycles - 1) on entry.
    function automatic logic [CW-1:0] dwell(input logic [2:0] s);
        case (s)
            S_SETUP:        dwell = CW'(SETUP_CYC - 1);
            S_PULSE, S_PRE: dwell = CW'(PULSE_CYC - 1);
            S_REC, S_HOLD:  dwell = CW'(HOLD_CYC - 1);
            default:        dwell = '0;
        endcase
    endfunction

    assign accept = (state == S_IDLE) && bus.VALID;

    always_comb begin
        state_nxt = state;
        case (state)
            S_INIT:  state_nxt = S_REC;
            S_REC:   if (cnt == '0) state_nxt = S_IDLE;
            S_IDLE:  if (bus.VALID) state_nxt = bus.OP ? S_PRE : S_SETUP;
            S_SETUP: if (cnt == '0) state_nxt = S_PULSE;
            S_PULSE: if (cnt == '0) state_nxt = S_HOLD;
            S_HOLD:  if (cnt == '0) state_nxt = S_IDLE;
            S_PRE:   if (cnt == '0) state_nxt = S_REC;
            default: state_nxt = S_INIT;
        endcase

        cnt_nxt = cnt;
        if (state_nxt != state) begin
            cnt_nxt = dwell(state_nxt);
        end else if (cnt != '0) begin
            cnt_nxt = cnt - 1'b1;
        end
    end

    // Outputs are computed from the next state so they change on the same
    // edge as the state register instead of being decoded after it.
    always_comb begin
        e_nxt = '0;
        if (state_nxt == S_PULSE && !bad_q) begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (int'(addr_q) == i) e_nxt[i] = 1'b1;
            end
        end
        done_nxt = (state_nxt == S_IDLE) &&
                   ((state == S_HOLD) || (state == S_REC && pre_q));
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state     <= S_INIT;
            cnt       <= '0;
            addr_q    <= '0;
            bad_q     <= 1'b0;
            pre_q     <= 1'b0;
            E         <= '0;
            D         <= '0;
            SETN      <= 1'b0;
            bus.READY <= 1'b0;
            bus.DONE  <= 1'b0;
            bus.ERR   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                addr_q <= bus.ADDR;
                bad_q  <= (int'(bus.ADDR) >= ENTRIES);
                if (!bus.OP) D <= bus.WDATA;
            end
            // Recovery after reset completes silently; after a preset it signals DONE.
            if (state_nxt == S_REC && state != S_REC) pre_q <= (state == S_PRE);
            E         <= e_nxt;
            SETN      <= !(state_nxt == S_PRE || state_nxt == S_INIT);
            bus.READY <= (state_nxt == S_IDLE);
            bus.DONE  <= done_nxt;
            bus.ERR   <= done_nxt && (state == S_HOLD) && bad_q;
        end
    end
endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__latwr_seq.sv
// Bench for the latch write sequencer: two instances (8 and 6 entries) share
// stimulus and are compared every cycle against a timeline reference model.
module tb_gf180mcu_fd_sc_mcu7t5v0__latwr_seq;
    localparam int S = 1;
    localparam int P = 2;
    localparam int H = 1;

    logic       clk;
    logic       rn;
    logic       valid;
    logic       op;
    logic [2:0] addr;
    logic [7:0] wdata;
    wire        vdd;
    wire        vss;
    assign vdd = 1'b1;
    assign vss = 1'b0;

    logic [7:0] e_a;
    logic [5:0] e_b;
    logic [7:0] d_a, d_b;
    logic       setn_a, setn_b;

    gf180mcu_fd_sc_mcu7t5v0__latwr_seq_if #(.ENTRIES(8), .WIDTH(8)) bus_a ();
    gf180mcu_fd_sc_mcu7t5v0__latwr_seq_if #(.ENTRIES(6), .WIDTH(8)) bus_b ();

    assign bus_a.VALID = valid;
    assign bus_a.OP    = op;
    assign bus_a.ADDR  = addr;
    assign bus_a.WDATA = wdata;
    assign bus_b.VALID = valid;
    assign bus_b.OP    = op;
    assign bus_b.ADDR  = addr;
    assign bus_b.WDATA = wdata;

    gf180mcu_fd_sc_mcu7t5v0__latwr_seq #(
        .ENTRIES(8), .WIDTH(8), .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H)
    ) dut_a (
        .CLK(clk), .RN(rn), .VDD(vdd), .VSS(vss), .bus(bus_a),
        .E(e_a), .D(d_a), .SETN(setn_a)
    );

    gf180mcu_fd_sc_mcu7t5v0__latwr_seq #(
        .ENTRIES(6), .WIDTH(8), .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H)
    ) dut_b (
        .CLK(clk), .RN(rn), .VDD(vdd), .VSS(vss), .bus(bus_b),
        .E(e_b), .D(d_b), .SETN(setn_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: a command timeline keyed on edge numbers.
    int         cyc = 0;
    bit         booted = 0;
    int         ready_after = 0;
    bit         have_cmd = 0;
    bit         c_op = 0;
    int         c_addr = 0;
    int         c_k = 0;
    int         c_end = 0;
    logic [7:0] last_d = '0;
    bit         acc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        acc = 0;
        if (!rn) return;
        if (!booted) begin
            booted      = 1;
            ready_after = cyc + H;
            return;
        end
        if (valid && cyc > ready_after) begin
            acc      = 1;
            have_cmd = 1;
            c_op     = op;
            c_addr   = int'(addr);
            c_k      = cyc;
            c_end    = cyc + (op ? (P + H) : (S + P + H));
            ready_after = c_end;
            if (!op) last_d = wdata;
        end
    endtask

    task automatic model_reset();
        booted   = 0;
        have_cmd = 0;
        last_d   = '0;
        acc      = 0;
    endtask

    function automatic logic [7:0] exp_e(input int ent);
        logic [7:0] one;
        one = 8'd1;
        if (rn && booted && have_cmd && !c_op && c_addr < ent &&
            cyc >= c_k + S && cyc < c_k + S + P)
            return one << c_addr;
        return 8'd0;
    endfunction

    task automatic check_all();
        logic ex_ready, ex_done, ex_setn, ex_err_a, ex_err_b;
        ex_ready = rn && booted && (cyc >= ready_after);
        ex_done  = rn && booted && have_cmd && (cyc == c_end);
        ex_setn  = rn && booted && !(have_cmd && c_op && cyc >= c_k && cyc < c_k + P);
        ex_err_a = ex_done && !c_op && (c_addr >= 8);
        ex_err_b = ex_done && !c_op && (c_addr >= 6);
        chk("ready_a", bus_a.READY, ex_ready);
        chk("ready_b", bus_b.READY, ex_ready);
        chk("done_a", bus_a.DONE, ex_done);
        chk("done_b", bus_b.DONE, ex_done);
        chk("err_a", bus_a.ERR, ex_err_a);
        chk("err_b", bus_b.ERR, ex_err_b);
        chk("setn_a", setn_a, ex_setn);
        chk("setn_b", setn_b, ex_setn);
        chk("e_a", e_a, exp_e(8));
        chk("e_b", e_b, exp_e(6));
        chk("d_a", d_a, last_d);
        chk("d_b", d_b, last_d);
        chk("e_onehot_a", ($countones(e_a) <= 1), 1);
        chk("e_setn_overlap_a", (!setn_a && (|e_a)), 0);
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    // Present a command and clock until it is accepted (bounded).
    task automatic issue(input logic o, input logic [2:0] a, input logic [7:0] w, input bit keep);
        valid = 1'b1; op = o; addr = a; wdata = w;
        for (int t = 0; t < 20; t++) begin
            step();
            if (acc) break;
        end
        chk("issue_accept", acc, 1);
        if (!keep) valid = 1'b0;
    endtask

    initial begin
        rn = 1'b0; valid = 1'b0; op = 1'b0; addr = '0; wdata = '0;

        #1;
        check_all();
        for (int i = 0; i < 3; i++) step();

        rn = 1'b1;
        step();
        chk("boot_setn", setn_a, 1);
        chk("boot_ready_early", bus_a.READY, 0);
        step();
        chk("boot_ready", bus_a.READY, 1);
        chk("boot_no_done", bus_a.DONE, 0);

        issue(1'b0, 3'd5, 8'hA5, 0);
        chk("wr_d", d_a, 8'hA5);
        chk("wr_e_setup", e_a, 8'h00);
        step();
        chk("wr_e_k1", e_a, 8'h20);
        step();
        chk("wr_e_k2", e_a, 8'h20);
        step();
        chk("wr_e_k3", e_a, 8'h00);
        step();
        chk("wr_done", bus_a.DONE, 1);
        chk("wr_err", bus_a.ERR, 0);
        step();
        chk("wr_done_once", bus_a.DONE, 0);

        issue(1'b1, 3'd2, 8'h77, 0);
        chk("pre_setn_k", setn_a, 0);
        step();
        chk("pre_setn_k1", setn_a, 0);
        chk("pre_e", e_a, 8'h00);
        step();
        chk("pre_setn_k2", setn_a, 1);
        step();
        chk("pre_done", bus_a.DONE, 1);
        chk("pre_d_kept", d_a, 8'hA5);

        issue(1'b0, 3'd7, 8'h3C, 0);
        for (int i = 0; i < 4; i++) step();
        chk("oor_done_b", bus_b.DONE, 1);
        chk("oor_err_b", bus_b.ERR, 1);
        chk("oor_e_b", e_b, 6'h00);
        chk("oor_err_a", bus_a.ERR, 0);

        issue(1'b0, 3'd0, 8'h11, 1);
        issue(1'b0, 3'd1, 8'h22, 0);
        chk("b2b_done_at_accept", bus_a.DONE, 0);
        for (int i = 0; i < 6; i++) step();
        chk("b2b_d", d_a, 8'h22);

        issue(1'b0, 3'd3, 8'h5A, 0);
        step();
        chk("mid_e_on", e_a, 8'h08);
        #2;
        rn = 1'b0;
        model_reset();
        #1;
        chk("mid_e_async", e_a, 8'h00);
        chk("mid_setn_async", setn_a, 0);
        check_all();
        step();
        step();
        rn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("mid_no_done", bus_a.DONE, 0);
        end

        for (int i = 0; i < 400; i++) begin
            if (!valid || acc) begin
                valid = ($urandom_range(0, 2) != 0);
                op    = ($urandom_range(0, 4) == 0);
                addr  = 3'($urandom);
                wdata = 8'($urandom);
            end
            step();
        end
        valid = 1'b0;
        for (int i = 0; i < 8; i++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
